// File: rtl/odo_sbox_pkg.sv
// odo_sbox_pkg: shared defaults, FSM states and lane slicing for the Odo S-box bank.
package odo_sbox_pkg;
   localparam int W_DEF = 6;
   localparam int LANES_DEF = 4;
   localparam int PIPE_DEF = 1;
   typedef enum logic {INIT, RUN} state_t;
   function automatic int lane_lo(input int k, input int w);
      return k * w;
   endfunction
endpackage

// File: rtl/odo_sbox_ram.sv
// odo_sbox_ram: 2^W x W simple dual-port RAM, registered read port, read-before-write.
module odo_sbox_ram #(
   parameter int W = 6
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         we,
   input  logic [W-1:0] waddr,
   input  logic [W-1:0] wdata,
   input  logic         re,
   input  logic [W-1:0] raddr,
   output logic [W-1:0] rdata
);
   logic [W-1:0] mem [2**W];
   always_ff @(posedge clk)
      if (we) mem[waddr] <= wdata;
   // read register holds its value between lookups
   always_ff @(posedge clk)
      if (rst) rdata <= '0;
      else if (re) rdata <= mem[raddr];
endmodule

// File: rtl/odo_sbox_bank.sv
// odo_sbox_bank: run-time reloadable multi-lane S-box table with identity init and PIPE-stage output.
module odo_sbox_bank
   import odo_sbox_pkg::*;
#(
   parameter int W = W_DEF,
   parameter int LANES = LANES_DEF,
   parameter int PIPE = PIPE_DEF
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               in_valid,
   output logic               in_ready,
   input  logic [LANES*W-1:0] in_idx,
   output logic               out_valid,
   output logic [LANES*W-1:0] out_data,
   input  logic               wr_valid,
   output logic               wr_ready,
   input  logic [W-1:0]       wr_addr,
   input  logic [W-1:0]       wr_data,
   output logic               init_done
);
   state_t state, state_nxt;
   logic [W:0] cnt, cnt_inc;
   logic run, accept, we;
   logic [W-1:0] waddr, wdata;
   logic [PIPE-1:0] vld;
   logic [LANES*W-1:0] rd;
   if (PIPE < 1 || PIPE > 2) begin : g_bad_pipe
      $error("odo_sbox_bank: PIPE must be 1 or 2");
   end
   assign run = state == RUN;
   assign in_ready = run;
   assign wr_ready = run;
   assign init_done = run;
   assign accept = in_valid && run;
   assign cnt_inc = cnt + (W+1)'(1);
   // INIT owns the write port to lay down the identity table
   always_comb begin
      state_nxt = state;
      we = run ? wr_valid : 1'b1;
      waddr = run ? wr_addr : cnt[W-1:0];
      wdata = run ? wr_data : cnt[W-1:0];
      if (!run && cnt_inc[W]) state_nxt = RUN;
   end
   always_ff @(posedge clk)
      if (rst) state <= INIT;
      else state <= state_nxt;
   always_ff @(posedge clk)
      if (rst) begin
         cnt <= '0;
         vld <= '0;
      end else begin
         if (!run) cnt <= cnt_inc;
         vld <= PIPE'({vld, accept});
      end
   for (genvar k = 0; k < LANES; k++) begin : g_lane
      odo_sbox_ram #(.W(W)) u_ram (
         .clk(clk), .rst(rst), .we(we), .waddr(waddr), .wdata(wdata), .re(accept),
         .raddr(in_idx[lane_lo(k, W) +: W]), .rdata(rd[lane_lo(k, W) +: W])
      );
   end
   if (PIPE == 2) begin : g_p2
      logic [LANES*W-1:0] hold;
      always_ff @(posedge clk)
         if (rst) hold <= '0;
         else if (vld[0]) hold <= rd;
      assign out_data = hold;
   end else begin : g_p1
      assign out_data = rd;
   end
   assign out_valid = vld[PIPE-1];
endmodule

// File: tb/tb_odo_sbox_bank.sv
// tb_odo_sbox_bank: vector table plus randomized scoreboard checks for two bank configurations.
module tb_odo_sbox_bank;
   logic clk = 1'b0;
   always #5 clk = ~clk;
   int errs = 0, checks = 0;

   logic a_rst = 1'b1, a_iv = 1'b0, a_wv = 1'b0, a_ir, a_ov, a_wr, a_id;
   logic [23:0] a_idx = '0, a_od;
   logic [5:0] a_wa = '0, a_wd = '0;
   odo_sbox_bank u_a (
      .clk(clk), .rst(a_rst), .in_valid(a_iv), .in_ready(a_ir), .in_idx(a_idx),
      .out_valid(a_ov), .out_data(a_od), .wr_valid(a_wv), .wr_ready(a_wr),
      .wr_addr(a_wa), .wr_data(a_wd), .init_done(a_id)
   );

   logic b_rst = 1'b1, b_iv = 1'b0, b_wv = 1'b0, b_ir, b_ov, b_wr, b_id;
   logic [19:0] b_idx = '0, b_od;
   logic [9:0] b_wa = '0, b_wd = '0;
   odo_sbox_bank #(.W(10), .LANES(2), .PIPE(2)) u_b (
      .clk(clk), .rst(b_rst), .in_valid(b_iv), .in_ready(b_ir), .in_idx(b_idx),
      .out_valid(b_ov), .out_data(b_od), .wr_valid(b_wv), .wr_ready(b_wr),
      .wr_addr(b_wa), .wr_data(b_wd), .init_done(b_id)
   );

   int a_tab [64];
   logic [23:0] a_last;
   int b_tab [1024];
   logic [19:0] b_last;
   logic [20:0] b_q [$];

   typedef struct {
      logic iv; logic [23:0] idx; logic wv; logic [5:0] wa; logic [5:0] wd;
      logic ev; logic [23:0] ed;
   } vec_t;
   vec_t vt [6];
   logic [5:0] la [64];

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errs++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
      end
   endtask

   function automatic logic [23:0] pk(input logic [5:0] l0, l1, l2, l3);
      return {l3, l2, l1, l0};
   endfunction

   task automatic a_reset(input string name);
      int n;
      a_rst = 1'b1; a_iv = 1'b0; a_wv = 1'b0;
      repeat (3) @(negedge clk);
      chk({name, " rst in_ready"}, 32'(a_ir), 32'd0);
      chk({name, " rst wr_ready"}, 32'(a_wr), 32'd0);
      chk({name, " rst init_done"}, 32'(a_id), 32'd0);
      chk({name, " rst out_valid"}, 32'(a_ov), 32'd0);
      chk({name, " rst out_data"}, 32'(a_od), 32'd0);
      // requests during INIT must be ignored
      a_rst = 1'b0; a_iv = 1'b1; a_wv = 1'b1; a_wa = 6'd3; a_wd = 6'h3f; a_idx = {4{6'd3}};
      n = 0;
      while (!a_ir && n < 200) begin
         chk({name, " init out_valid"}, 32'(a_ov), 32'd0);
         n++;
         @(negedge clk);
      end
      a_iv = 1'b0; a_wv = 1'b0;
      chk({name, " init cycles"}, 32'(n), 32'd64);
      chk({name, " init_done"}, 32'(a_id), 32'd1);
      chk({name, " wr_ready"}, 32'(a_wr), 32'd1);
      for (int i = 0; i < 64; i++) a_tab[i] = i;
      a_last = '0;
   endtask

   task automatic a_step(input logic iv, input logic [23:0] idx, input logic wv,
                         input logic [5:0] wa, input logic [5:0] wd, input string name);
      logic [23:0] e;
      e = a_last;
      if (iv) for (int k = 0; k < 4; k++) e[k*6 +: 6] = 6'(a_tab[idx[k*6 +: 6]]);
      a_iv = iv; a_idx = idx; a_wv = wv; a_wa = wa; a_wd = wd;
      @(negedge clk);
      chk({name, " out_valid"}, 32'(a_ov), 32'(iv));
      chk({name, " out_data"}, 32'(a_od), 32'(e));
      a_last = e;
      if (wv) a_tab[wa] = int'(wd);
      a_iv = 1'b0; a_wv = 1'b0;
   endtask

   task automatic b_reset(input string name);
      int n;
      b_rst = 1'b1; b_iv = 1'b0; b_wv = 1'b0;
      repeat (3) begin
         @(negedge clk);
         chk({name, " rst out_valid"}, 32'(b_ov), 32'd0);
      end
      chk({name, " rst out_data"}, 32'(b_od), 32'd0);
      chk({name, " rst in_ready"}, 32'(b_ir), 32'd0);
      b_rst = 1'b0;
      n = 0;
      while (!b_ir && n < 2000) begin
         n++;
         @(negedge clk);
      end
      chk({name, " init cycles"}, 32'(n), 32'd1024);
      chk({name, " init_done"}, 32'(b_id), 32'd1);
      for (int i = 0; i < 1024; i++) b_tab[i] = i;
      b_last = '0;
      b_q.delete();
   endtask

   // result of a request is compared two steps after it is presented
   task automatic b_step(input logic iv, input logic [19:0] idx, input logic wv,
                         input logic [9:0] wa, input logic [9:0] wd);
      logic [20:0] e;
      e = '0;
      if (iv) begin
         e[20] = 1'b1;
         for (int k = 0; k < 2; k++) e[k*10 +: 10] = 10'(b_tab[idx[k*10 +: 10]]);
      end
      b_q.push_back(e);
      b_iv = iv; b_idx = idx; b_wv = wv; b_wa = wa; b_wd = wd;
      @(negedge clk);
      if (wv) b_tab[wa] = int'(wd);
      if (b_q.size() == 2) begin
         e = b_q.pop_front();
         if (e[20]) b_last = e[19:0];
         chk("b out_valid", 32'(b_ov), 32'(e[20]));
         chk("b out_data", 32'(b_od), 32'(b_last));
      end
      b_iv = 1'b0; b_wv = 1'b0;
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      a_reset("a");
      a_step(1'b1, pk(6'h2a, 6'd3, 6'd0, 6'd63), 1'b0, '0, '0, "a identity");
      chk("a lane0 0x2a", 32'(a_od[5:0]), 32'h2a);
      for (int i = 0; i < 64; i++) la[i] = 6'((i * 7 + 3) & 63);
      la[0] = 6'h0b; la[1] = 6'h11; la[2] = 6'h26; la[5] = 6'h14; la[27] = 6'h04; la[63] = 6'h12;
      for (int i = 0; i < 64; i++) a_step(1'b0, '0, 1'b1, 6'(i), la[i], "a load");
      vt[0] = '{1'b1, pk(6'd0, 6'd1, 6'd63, 6'd27), 1'b0, 6'd0, 6'd0, 1'b1, pk(6'h0b, 6'h11, 6'h12, 6'h04)};
      vt[1] = '{1'b0, pk(6'd9, 6'd9, 6'd9, 6'd9), 1'b0, 6'd0, 6'd0, 1'b0, pk(6'h0b, 6'h11, 6'h12, 6'h04)};
      vt[2] = '{1'b1, pk(6'd5, 6'd5, 6'd5, 6'd5), 1'b1, 6'd5, 6'h3f, 1'b1, pk(6'h14, 6'h14, 6'h14, 6'h14)};
      vt[3] = '{1'b1, pk(6'd5, 6'd5, 6'd5, 6'd5), 1'b0, 6'd0, 6'd0, 1'b1, pk(6'h3f, 6'h3f, 6'h3f, 6'h3f)};
      vt[4] = '{1'b1, pk(6'd0, 6'd5, 6'd2, 6'd63), 1'b1, 6'd63, 6'h00, 1'b1, pk(6'h0b, 6'h3f, 6'h26, 6'h12)};
      vt[5] = '{1'b1, pk(6'd27, 6'd1, 6'd63, 6'd63), 1'b0, 6'd0, 6'd0, 1'b1, pk(6'h04, 6'h11, 6'h00, 6'h00)};
      for (int i = 0; i < 6; i++) begin
         a_iv = vt[i].iv; a_idx = vt[i].idx; a_wv = vt[i].wv; a_wa = vt[i].wa; a_wd = vt[i].wd;
         @(negedge clk);
         chk($sformatf("a vec%0d out_valid", i), 32'(a_ov), 32'(vt[i].ev));
         chk($sformatf("a vec%0d out_data", i), 32'(a_od), 32'(vt[i].ed));
         if (vt[i].wv) a_tab[vt[i].wa] = int'(vt[i].wd);
         a_last = vt[i].ed;
      end
      a_iv = 1'b0; a_wv = 1'b0;
      for (int i = 0; i < 100; i++) begin
         logic [23:0] idx;
         idx = 24'($urandom);
         a_step(1'($urandom), idx, 1'($urandom),
                ($urandom_range(0, 3) == 0) ? idx[5:0] : 6'($urandom), 6'($urandom), "a rand");
      end

      b_reset("b");
      b_step(1'b0, '0, 1'b1, 10'h3ff, 10'h001);
      b_step(1'b1, {10'h3ff, 10'h3ff}, 1'b0, '0, '0);
      b_step(1'b0, '0, 1'b0, '0, '0);
      chk("b 0x3ff both lanes", 32'(b_od), 32'h00401);
      for (int i = 0; i < 100; i++) begin
         logic [19:0] idx;
         idx = 20'($urandom);
         b_step(1'b1, idx, 1'($urandom),
                ($urandom_range(0, 3) == 0) ? idx[9:0] : 10'($urandom), 10'($urandom));
      end
      b_step(1'b0, '0, 1'b0, '0, '0);
      b_step(1'b1, {10'h155, 10'h2aa}, 1'b0, '0, '0);
      b_step(1'b1, {10'h3ff, 10'h000}, 1'b0, '0, '0);
      // reset with two lookups in flight: no late emission allowed
      b_rst = 1'b1; b_iv = 1'b1; b_idx = {10'h3ff, 10'h3ff};
      @(negedge clk);
      chk("b midrst out_valid", 32'(b_ov), 32'd0);
      b_reset("b2");
      b_step(1'b1, {10'h3ff, 10'h123}, 1'b0, '0, '0);
      b_step(1'b0, '0, 1'b0, '0, '0);
      b_step(1'b0, '0, 1'b0, '0, '0);
      chk("b identity after rst", 32'(b_od), {12'd0, 10'h3ff, 10'h123});

      $display("Result: errors=%0d of %0d checks", errs, checks);
      $finish;
   end
endmodule
